// File: rtl/imem_loader.sv
// imem_loader: byte-stream frame loader for a synchronous-read 32-bit instruction memory.
// Define IMEM_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte per frame.
module imem_loader #(
    parameter int         ADDR_WIDTH_I = 10,
    parameter logic [7:0] SYNC_BYTE    = 8'hA5
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [7:0]              rx_data,
    input  logic                    rx_valid,
    output logic                    rx_ready,
    input  logic [ADDR_WIDTH_I-1:0] imem_addr,
    output logic [31:0]             data_imem,
    output logic                    core_rst_n,
    output logic                    load_busy,
    output logic                    load_done,
    output logic                    load_error
);
`ifdef IMEM_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {IDLE, LEN_LO, LEN_HI, DATA, CHECK, DONE, ERROR} state_t;
    localparam state_t FIN_ST = CHECK;
    logic [7:0] csum_q, csum_d;
`else
    typedef enum logic [2:0] {IDLE, LEN_LO, LEN_HI, DATA, DONE, ERROR} state_t;
    localparam state_t FIN_ST = DONE;
`endif
    logic [31:0]             mem [2**ADDR_WIDTH_I];
    state_t                  state_q, state_d;
    logic                    rx_ready_q;
    logic [7:0]              len_lo_q, len_lo_d;
    logic [15:0]             n_q, n_d;
    logic [ADDR_WIDTH_I-1:0] word_q, word_d;
    logic [1:0]              byte_q, byte_d;
    logic [23:0]             asm_q, asm_d;
    logic [31:0]             data_q;
    logic                    acc, we;

    assign acc        = rx_valid & rx_ready_q;
    assign rx_ready   = rx_ready_q;
    assign data_imem  = data_q;
    assign load_busy  = !(state_q inside {IDLE, DONE, ERROR});
    assign load_done  = state_q == DONE;
    assign core_rst_n = state_q == DONE;
    assign load_error = state_q == ERROR;

    always_comb begin
        state_d  = state_q;
        len_lo_d = len_lo_q;
        n_d      = n_q;
        word_d   = word_q;
        byte_d   = byte_q;
        asm_d    = asm_q;
        we       = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
        csum_d   = csum_q;
`endif
        if (acc) begin
            case (state_q)
                IDLE, DONE, ERROR: begin
                    if (rx_data == SYNC_BYTE) begin
                        state_d = LEN_LO;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        csum_d  = 8'd0;
`endif
                    end
                end
                LEN_LO: begin
                    len_lo_d = rx_data;
                    state_d  = LEN_HI;
                end
                LEN_HI: begin
                    n_d     = {rx_data, len_lo_q};
                    word_d  = '0;
                    byte_d  = 2'd0;
                    state_d = (n_d == 16'd0) ? FIN_ST :
                              (32'(n_d) > (32'd1 << ADDR_WIDTH_I)) ? ERROR : DATA;
                end
                DATA: begin
                    byte_d = byte_q + 2'd1;
                    asm_d  = {rx_data, asm_q[23:8]};
`ifdef IMEM_LOADER_CHECKSUM_EN
                    csum_d = csum_q ^ rx_data;
`endif
                    if (byte_q == 2'd3) begin
                        we     = 1'b1;
                        word_d = word_q + 1'b1;
                        if (32'(word_q) + 32'd1 == 32'(n_q)) state_d = FIN_ST;
                    end
                end
`ifdef IMEM_LOADER_CHECKSUM_EN
                CHECK: state_d = (rx_data == csum_q) ? DONE : ERROR;
`endif
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            rx_ready_q <= 1'b0;
            len_lo_q   <= 8'd0;
            n_q        <= 16'd0;
            word_q     <= '0;
            byte_q     <= 2'd0;
            asm_q      <= 24'd0;
            data_q     <= 32'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q     <= 8'd0;
`endif
        end else begin
            state_q    <= state_d;
            rx_ready_q <= 1'b1;
            len_lo_q   <= len_lo_d;
            n_q        <= n_d;
            word_q     <= word_d;
            byte_q     <= byte_d;
            asm_q      <= asm_d;
            data_q     <= mem[imem_addr];
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q     <= csum_d;
`endif
        end
    end

    // Memory is deliberately outside reset so an image survives a loader reset.
    always_ff @(posedge clk) begin
        if (we) mem[word_q] <= {rx_data, asm_q};
    end
endmodule
